// File: rtl/seq_shift_add_multiplier_if.sv
// Start/busy/done handshake and operand/result bus for seq_shift_add_multiplier.
// master drives the request; slave is the multiplier.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, WIDTH+1 cycle latency.
// Define SIGNED_MULT_EN for two's-complement operands (sign/magnitude around the unsigned core).
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    reset,
  seq_shift_add_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     mcand;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     acc_sum;
  logic [PW-1:0]     result;
  logic [PW-1:0]     product_r;
  logic [WIDTH-1:0]  mplr;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [CW-1:0]     count;
  logic              accept;
  logic              last;

`ifdef SIGNED_MULT_EN
  logic neg;

  // -2^(WIDTH-1) maps to 2^(WIDTH-1), still representable as WIDTH unsigned bits
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign op_a   = magnitude(bus.a);
  assign op_b   = magnitude(bus.b);
  assign result = apply_sign(acc_sum, neg);
`else
  assign op_a   = bus.a;
  assign op_b   = bus.b;
  assign result = acc_sum;
`endif

  assign accept  = bus.start && (state != RUN);
  assign last    = (state == RUN) && (count == CW'(WIDTH - 1));
  assign acc_sum = mplr[0] ? (acc + mcand) : acc;

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = accept ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.product = product_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      count     <= '0;
      product_r <= '0;
`ifdef SIGNED_MULT_EN
      neg       <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        // operand capture
        mcand <= {{WIDTH{1'b0}}, op_a};
        mplr  <= op_b;
        acc   <= '0;
        count <= '0;
`ifdef SIGNED_MULT_EN
        neg   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`endif
      end else if (state == RUN) begin
        // one partial product per cycle
        acc   <= acc_sum;
        mcand <= mcand << 1;
        mplr  <= mplr >> 1;
        count <= count + CW'(1);
        if (last) product_r <= result;
      end
    end
  end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: vector table, handshake corner cases, random ops.
module tb_seq_shift_add_multiplier;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_shift_add_multiplier_if #(.WIDTH(W)) bus8 ();
  seq_shift_add_multiplier_if #(.WIDTH(4)) bus4 ();

  seq_shift_add_multiplier #(.WIDTH(W)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  seq_shift_add_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer multiplication of the operands as the mode interprets them
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
`ifdef SIGNED_MULT_EN
    p = int'($signed(x)) * int'($signed(y));
`else
    p = int'(x) * int'(y);
`endif
    return 16'(p);
  endfunction

  // Called in the first cycle after the accepting edge; checks busy window, done pulse and product.
  task automatic finish_op(input logic [15:0] exp, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < W; i++) begin
      if (!(bus8.busy === 1'b1 && bus8.done === 1'b0)) bad++;
      @(negedge clk);
    end
    check({name, "_busy"}, bad, 0);
    check({name, "_done"}, {31'b0, bus8.done}, 32'd1);
    check({name, "_prod"}, {16'b0, bus8.product}, {16'b0, exp});
    @(negedge clk);
    check({name, "_pulse"}, {30'b0, bus8.done, bus8.busy}, 32'd0);
    check({name, "_hold"}, {16'b0, bus8.product}, {16'b0, exp});
  endtask

  task automatic do_mul(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp,
                        input string name);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = x;
    bus8.b     = y;
    @(negedge clk);
    bus8.start = 1'b0;
    finish_op(exp, name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    logic [7:0] ra, rb;

`ifdef SIGNED_MULT_EN
    vecs[0] = '{8'hFD, 8'h05, 16'hFFF1};
    vecs[1] = '{8'h80, 8'h80, 16'h4000};
    vecs[2] = '{8'h80, 8'h01, 16'hFF80};
    vecs[3] = '{8'h06, 8'h07, 16'h002A};
    vecs[4] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[5] = '{8'h7F, 8'h81, 16'hC0FF};
    vecs[6] = '{8'h00, 8'h80, 16'h0000};
    vecs[7] = '{8'hFD, 8'hFD, 16'h0009};
`else
    vecs[0] = '{8'd255, 8'd255, 16'hFE01};
    vecs[1] = '{8'd0,   8'd200, 16'h0000};
    vecs[2] = '{8'd12,  8'd10,  16'd120};
    vecs[3] = '{8'd6,   8'd7,   16'd42};
    vecs[4] = '{8'd1,   8'd1,   16'd1};
    vecs[5] = '{8'd128, 8'd2,   16'd256};
    vecs[6] = '{8'd200, 8'd0,   16'd0};
    vecs[7] = '{8'd170, 8'd85,  16'd14450};
`endif

    reset      = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    repeat (2) @(negedge clk);
    check("reset_state8", {bus8.busy, bus8.done, 14'b0, bus8.product}, 32'd0);
    check("reset_state4", {bus4.busy, bus4.done, 22'b0, bus4.product}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      do_mul(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    // start during busy is ignored; start held into the done cycle is accepted back-to-back
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'd12;
    bus8.b     = 8'd10;
    @(negedge clk);
    bus8.start = 1'b0;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'd3;
    bus8.b     = 8'd3;
    repeat (W - 1) @(negedge clk);
    check("ignore_done", {30'b0, bus8.done, bus8.busy}, 32'd2);
    check("ignore_prod", {16'b0, bus8.product}, 32'd120);
    @(negedge clk);
    bus8.start = 1'b0;
    finish_op(16'd9, "b2b");

    // reset in the third busy cycle aborts the operation without a done pulse
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'd50;
    bus8.b     = 8'd50;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_state", {bus8.busy, bus8.done, 14'b0, bus8.product}, 32'd0);
    reset = 1'b0;
    bad = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) bad++;
    end
    check("abort_no_done", bad, 0);
    do_mul(8'd6, 8'd7, 16'd42, "after_abort");

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      do_mul(ra, rb, ref_mul(ra, rb), $sformatf("rand%0d", i));
    end

    // WIDTH=4 instance: busy for 4 cycles, done in the 5th
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a     = 4'b1001;
    bus4.b     = 4'b0111;
    @(negedge clk);
    bus4.start = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (!(bus4.busy === 1'b1 && bus4.done === 1'b0)) bad++;
      @(negedge clk);
    end
    check("w4_busy", bad, 0);
    check("w4_done", {31'b0, bus4.done}, 32'd1);
`ifdef SIGNED_MULT_EN
    check("w4_prod", {24'b0, bus4.product}, 32'hCF);
`else
    check("w4_prod", {24'b0, bus4.product}, 32'd63);
`endif
    @(negedge clk);
    check("w4_pulse", {30'b0, bus4.done, bus4.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
Parametrised sequential unsigned multiplier. It is the successor to the fixed 4x4 combinational array multiplier and uses the same shift-and-add partial-product method, but evaluates one multiplier bit per clock. It trades latency for area and adds a start/busy/done handshake, so it can sit inside datapaths of any width.

Parameters:
WIDTH, 8, operand width in bits; must be >= 2. Product width is 2*WIDTH.

Ports:
clk      input   1          system clock; all state updates on the rising edge
reset    input   1          synchronous, active-high reset
start    input   1          request a multiplication; sampled only when busy=0
a        input   WIDTH      multiplicand; sampled on the accepted start edge
b        input   WIDTH      multiplier; sampled on the accepted start edge
busy     output  1          high while an operation is in progress
done     output  1          single-cycle pulse; product is valid from this cycle on
product  output  2*WIDTH    registered result; held until the next completion

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (reset=1 at a clk edge) overrides everything, including an operation in flight:
  - state=IDLE, busy=0, done=0, product=0, internal registers=0.
  - No done pulse is emitted for an aborted operation.
- Accept rule: start is accepted when state is IDLE or DONE (busy=0).
  - On accept: mcand <= zero-extended a (2*WIDTH bits); mplr <= b; acc <= 0; count <= 0; state <= RUN.
  - start while busy=1 is ignored; a and b are not re-sampled.
- RUN, one iteration per cycle:
  - If mplr[0]=1: acc <= acc + mcand. The addition is 2*WIDTH bits wide and never overflows.
  - mcand <= mcand << 1; mplr <= mplr >> 1; count <= count + 1.
  - count is $clog2(WIDTH+1) bits.
- Completion: on the edge that performs iteration WIDTH, product <= final accumulated sum and state <= DONE.
- DONE lasts exactly one cycle with done=1, busy=0.
  - If start=1 in that cycle, a new operation is accepted (back-to-back) and the next state is RUN.
  - Otherwise the next state is IDLE.
- Timing:
  - Start accepted at edge E0; busy=1 during cycles E0+1 .. E0+WIDTH.
  - done=1 and the new product are visible in the cycle after edge E0+WIDTH. Latency is WIDTH+1 cycles from the start cycle to the done cycle.
  - Throughput: one result per WIDTH+1 cycles.
- busy is 1 exactly when state=RUN; done is 1 exactly when state=DONE. Both are registered decodes with no combinational path from inputs.
- product changes only on a completion edge or on reset.
- Boundary cases:
  - a=0 or b=0 gives product=0 and still takes the full latency; there is no early termination.
  - All-ones operands give (2^WIDTH-1)^2.

Optional Feature:
SIGNED_MULT_EN
- Defined: a and b are treated as two's complement.
  - On accept, the block latches |a| and |b| as WIDTH-bit unsigned magnitudes and records neg = a[WIDTH-1] XOR b[WIDTH-1].
  - The most-negative value -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits.
  - At completion: product <= neg ? -acc : acc (2*WIDTH-bit two's complement).
  - Latency is unchanged.
- Not defined: purely unsigned operation as described above, with no sign logic synthesised.

Test Plan:
- WIDTH=4, a=4'b1001, b=4'b0111, pulse start -> busy high for 4 cycles, then done pulse in cycle 5 with product=8'b00111111 (63).
- WIDTH=8, a=255, b=255 -> product=16'hFE01 after 9 cycles; a=0, b=200 -> product=0 with the same 9-cycle latency.
- WIDTH=8, a=12, b=10, then during busy drive start=1 with a=3, b=3 -> start ignored, product=120; then start held high in the done cycle with a=3, b=3 -> accepted back-to-back, next done gives 9.
- WIDTH=8, start a=50, b=50, assert reset in the 3rd busy cycle -> next cycle busy=0, done=0, product=0, no later done pulse; a fresh a=6, b=7 then yields 42.
- SIGNED_MULT_EN, WIDTH=8: a=-3 (8'hFD), b=5 -> product=16'hFFF1; a=-128, b=-128 -> 16'h4000; a=-128, b=1 -> 16'hFF80.
